pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Every cycle it decides which of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers load, hold or take a bubble. Inputs are load-use hazards, taken branches and a ready handshake from a multi-cycle data memory. It also runs a memory-wait timeout and saturating stall/flush counters for debug.

## Interface
- MEM_TIMEOUT, 64: consecutive data-memory wait cycles before the error trap fires; legal range 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- IdEx_MemRead  in  1  instruction in ID/EX is a load.
- IdEx_Rt  in  5  load destination register in ID/EX.
- IfId_Rs, IfId_Rt  in  5 each  source registers of the instruction in IF/ID.
- Ex_BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- ExMem_MemReq  in  1  EX/MEM instruction accesses data memory (MemRead | MemWrite).
- DataMemory_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC loads its next value.
- IfId_Write  out  1  IF/ID loads; when 0 it holds.
- IfId_Flush  out  1  IF/ID loads a NOP.
- IdEx_Write  out  1  ID/EX loads; when 0 it holds.
- IdEx_Bubble  out  1  ID/EX loads zeroed control bits.
- ExMem_Write  out  1  EX/MEM loads; when 0 it holds.
- MemWb_Bubble  out  1  MEM/WB loads wb_RegWrite=0, wb_MemToReg=0.
- mem_error  out  1  sticky memory-timeout flag.
- stall_count  out  CNT_W  saturating count of cycles with PC_Write=0.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- Derived terms:
  - load_use = IdEx_MemRead & IdEx_Rt≠0 & (IdEx_Rt==IfId_Rs | IdEx_Rt==IfId_Rt).
  - mem_wait = ExMem_MemReq & ~DataMemory_Ready.
- FSM states: RUN, MEM_WAIT, ERROR. A 16-bit wait counter wcnt counts cycles spent waiting.
- RUN:
  - If mem_wait, go to MEM_WAIT with wcnt=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - If ~mem_wait, go to RUN with wcnt=0.
  - Else if wcnt==MEM_TIMEOUT, go to ERROR and set mem_error=1.
  - Else wcnt+1.
- ERROR: absorbing. Leave only by reset.
- Outputs are combinational from state and inputs. First matching row wins:
  1. ERROR or mem_wait (freeze): PC_Write, IfId_Write, IdEx_Write and ExMem_Write all 0. MemWb_Bubble=1. IfId_Flush=0, IdEx_Bubble=0.
  2. Ex_BranchTaken (flush): all writes 1, IfId_Flush=1, IdEx_Bubble=1, MemWb_Bubble=0. A coincident load_use is discarded, because the offending instruction is itself flushed.
  3. load_use: PC_Write=0, IfId_Write=0. IdEx_Write=1 with IdEx_Bubble=1. ExMem_Write=1, MemWb_Bubble=0.
  4. Default: all writes 1, all flush/bubble outputs 0.
- stall_count increments in any cycle where PC_Write=0 and FSM≠ERROR; it saturates at all-ones.
- flush_count increments in any cycle where row 2 applies; it saturates at all-ones.

## Timing
- Reset (asynchronous, immediate):
  - State RUN, wcnt=0, mem_error=0, both counters 0.
  - While reset is high, all *_Write outputs are forced to 0 and IfId_Flush, IdEx_Bubble and MemWb_Bubble are forced to 1.
- Reset during MEM_WAIT or ERROR returns to RUN with no memory of the pending access.
- Control latency is zero: decisions apply to the register loads at the next rising clk edge.
- Load-use costs exactly 1 stall cycle. On the next cycle ID/EX holds a bubble, so IdEx_MemRead=0 and load_use deasserts naturally.
- Zero-wait memory (DataMemory_Ready=1 in the same cycle as ExMem_MemReq) adds no stall.
- An access with N not-ready cycles costs N freeze cycles.
- The trap fires on a wait of MEM_TIMEOUT+1 cycles: mem_error rises at the edge ending the (MEM_TIMEOUT+1)th consecutive not-ready cycle.
- If DataMemory_Ready rises on the same cycle wcnt==MEM_TIMEOUT, the access completes and no error is raised.
- A branch and a memory wait in the same cycle: freeze wins. The branch is re-evaluated every cycle until the freeze ends, then flushes exactly once.

## Test plan
- Reset check: reset=1 mid-run → all outputs at their reset values immediately, before any clk edge. Release reset and drive no hazards → PC_Write=1 and all flush/bubble outputs 0 at the first edge.
- Load-use: lw $8 in ID/EX, IfId_Rs=8 → exactly 1 cycle with PC_Write=0 and IdEx_Bubble=1, then normal flow; stall_count=1. Repeat with IdEx_Rt=0 → no stall.
- Memory wait: ExMem_MemReq=1 with Ready low for 3 cycles → 3 freeze cycles with MemWb_Bubble=1, EX/MEM holds, stall_count=3, then resume in RUN.
- Timeout: MEM_TIMEOUT=4 with Ready held low → mem_error=1 after the 5th wait cycle and freeze persists. Ready rising afterwards does not clear it; only reset does.
- Priority: Ex_BranchTaken and load_use together → IfId_Flush=1, IdEx_Bubble=1, PC_Write=1, flush_count+1. Branch during mem_wait → flush occurs only in the first cycle after Ready=1.
- Saturation: with CNT_W=4, force 20 stall cycles → stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch flush,
// data-memory wait freeze with timeout trap, and saturating debug counters.
// Ports:
//   clk, reset                        clock, async active-high reset
//   IdEx_MemRead, IdEx_Rt             load in ID/EX and its destination
//   IfId_Rs, IfId_Rt                  sources of the instruction in IF/ID
//   Ex_BranchTaken                    taken branch resolved in EX
//   ExMem_MemReq, DataMemory_Ready    data-memory request / completion
//   PC_Write, IfId_Write, IfId_Flush  PC and IF/ID controls
//   IdEx_Write, IdEx_Bubble           ID/EX controls
//   ExMem_Write, MemWb_Bubble         EX/MEM and MEM/WB controls
//   mem_error                         sticky memory-timeout flag
//   stall_count, flush_count          saturating debug counters
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IdEx_MemRead,
  input  logic [4:0]       IdEx_Rt,
  input  logic [4:0]       IfId_Rs,
  input  logic [4:0]       IfId_Rt,
  input  logic             Ex_BranchTaken,
  input  logic             ExMem_MemReq,
  input  logic             DataMemory_Ready,
  output logic             PC_Write,
  output logic             IfId_Write,
  output logic             IfId_Flush,
  output logic             IdEx_Write,
  output logic             IdEx_Bubble,
  output logic             ExMem_Write,
  output logic             MemWb_Bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic load_use, mem_wait, freeze;
  logic r_rst, r_frz, r_fl, r_lu;

  assign load_use = IdEx_MemRead && (IdEx_Rt != 5'd0) &&
                    ((IdEx_Rt == IfId_Rs) || (IdEx_Rt == IfId_Rt));
  assign mem_wait = ExMem_MemReq && !DataMemory_Ready;
  assign freeze   = (state_q == S_ERR) || mem_wait;

  // Mutually exclusive row selects, highest priority first.
  assign r_rst = reset;
  assign r_frz = !reset && freeze;
  assign r_fl  = !reset && !freeze && Ex_BranchTaken;
  assign r_lu  = !reset && !freeze && !Ex_BranchTaken && load_use;

  always_comb begin
    PC_Write     = 1'b1;
    IfId_Write   = 1'b1;
    IfId_Flush   = 1'b0;
    IdEx_Write   = 1'b1;
    IdEx_Bubble  = 1'b0;
    ExMem_Write  = 1'b1;
    MemWb_Bubble = 1'b0;
    unique case (1'b1)
      r_rst: begin
        PC_Write     = 1'b0;
        IfId_Write   = 1'b0;
        IdEx_Write   = 1'b0;
        ExMem_Write  = 1'b0;
        IfId_Flush   = 1'b1;
        IdEx_Bubble  = 1'b1;
        MemWb_Bubble = 1'b1;
      end
      r_frz: begin
        PC_Write     = 1'b0;
        IfId_Write   = 1'b0;
        IdEx_Write   = 1'b0;
        ExMem_Write  = 1'b0;
        MemWb_Bubble = 1'b1;
      end
      r_fl: begin
        IfId_Flush  = 1'b1;
        IdEx_Bubble = 1'b1;
      end
      r_lu: begin
        PC_Write    = 1'b0;
        IfId_Write  = 1'b0;
        IdEx_Bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      S_WAIT: begin
        if (!mem_wait) begin
          state_d = S_RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == TMO) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_ERR: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      wcnt_q  <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      if (!PC_Write && (state_q != S_ERR) && (stall_q != CMAX))
        stall_q <= stall_q + CNT_W'(1);
      if (r_fl && (flush_q != CMAX))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign mem_error   = err_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
